// File: rtl/uint2oh_pkg.sv
// Shared sizing helpers for the streaming index -> one-hot decoder.
package uint2oh_pkg;

    // Index width for a given one-hot width; a 1-entry vector still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned output_width);
        return (output_width > 1) ? $clog2(output_width) : 1;
    endfunction

    // Buffer slot payload: {err, oh}.
    function automatic int unsigned slot_width(input int unsigned output_width);
        return output_width + 1;
    endfunction

endpackage

// File: rtl/uint2oh_dec.sv
// Combinational unsigned index -> one-hot decoder with out-of-range flag.
module uint2oh_dec
    import uint2oh_pkg::*;
#(
    parameter  int unsigned OutputWidth = 8,
    localparam int unsigned IndexWidth  = idx_width(OutputWidth)
) (
    input  logic [IndexWidth-1:0]  idx_i,
    output logic [OutputWidth-1:0] oh_c,
    output logic                   err_c
);

    // One extra bit so OutputWidth itself is representable in the range compare.
    localparam int unsigned CmpWidth = IndexWidth + 1;

    logic [CmpWidth-1:0] idx_ext;

    assign idx_ext = CmpWidth'(idx_i);

    always_comb begin
        oh_c = '0;
        for (int unsigned i = 0; i < OutputWidth; i++) begin
            oh_c[i] = (idx_ext == CmpWidth'(i));
        end
        err_c = (idx_ext >= CmpWidth'(OutputWidth));
    end

endmodule

// File: rtl/uint2oh_stream.sv
// Streaming index -> one-hot decoder: valid/ready in, registered valid/ready out, 2-entry skid buffer.
module uint2oh_stream
    import uint2oh_pkg::*;
#(
    parameter  int unsigned OutputWidth = 8,
    localparam int unsigned IndexWidth  = idx_width(OutputWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [IndexWidth-1:0]  idx_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [OutputWidth-1:0] oh_o,
    output logic                   err_o
);

    localparam int unsigned SlotWidth = slot_width(OutputWidth);

    logic                   out_valid_q, out_valid_d;
    logic [SlotWidth-1:0]   out_data_q,  out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [SlotWidth-1:0]   skid_data_q,  skid_data_d;

    logic [OutputWidth-1:0] dec_oh;
    logic                   dec_err;
    logic [SlotWidth-1:0]   new_data;
    logic                   acc;
    logic                   pop;

    uint2oh_dec #(
        .OutputWidth (OutputWidth)
    ) u_dec (
        .idx_i (idx_i),
        .oh_c  (dec_oh),
        .err_c (dec_err)
    );

    assign new_data = {dec_err, dec_oh};

    // Ready depends only on skid occupancy, so there is no ready_i -> ready_o path.
    assign ready_o = ~skid_valid_q;
    assign acc     = valid_i & ready_o & ~flush_i;
    assign pop     = out_valid_q & ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
            end else begin
                out_valid_d = acc;
                out_data_d  = acc ? new_data : '0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign valid_o = out_valid_q;
    assign oh_o    = out_data_q[OutputWidth-1:0];
    assign err_o   = out_data_q[SlotWidth-1];

endmodule
